// File: rtl/tpu_stream_core.sv
// tpu_stream_core: streaming N x N output-stationary systolic matrix multiplier, C = A * B.
//
// A job is requested with start and computes C = A * B over K beats. Each beat presents
// column k of A on a_vec_flat and row k of B on b_vec_flat. With cfg_acc set (and a
// completed job since reset) the new product is added onto the previous C. When the job
// is finished, the N rows of C are read out one row per handshake.
//
// Ports:
//   clk, rst_n              single clock, asynchronous active-low reset
//   start, abort            job request (accepted in IDLE only), job cancel
//   cfg_k, cfg_acc          inner dimension K; accumulate onto previous C (both sampled on start)
//   in_valid/in_ready       operand beat handshake, a_vec_flat / b_vec_flat = {x[N-1],...,x[0]}
//   out_valid/out_ready     result row handshake, out_row = {C[r][N-1],...,C[r][0]}
//   out_idx, out_last       current row index, high on row N-1
//   busy, done              job active, one-cycle completion pulse
//   perf_cycles             busy-cycle count of the last completed job
//
// Build option: define TPU_PERF_CNT_EN to build the busy-cycle counter behind perf_cycles;
// when it is undefined, perf_cycles is tied to zero.
module tpu_stream_core #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int ACC_W = 2 * W + 4,
  parameter int KW    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [KW-1:0]        cfg_k,
  input  logic                 cfg_acc,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*W-1:0]       a_vec_flat,
  input  logic [N*W-1:0]       b_vec_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*ACC_W-1:0]   out_row,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          perf_cycles
);

  localparam int IW         = $clog2(N);
  localparam int DrainLast  = 2 * (N - 1);
  localparam int DW         = $clog2(2 * N);

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StRead} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   beat_q, beat_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [IW-1:0]   row_q, row_d;
  logic            prior_q, prior_d;
  logic            done_q, done_d;

  logic            arr_en, arr_clr, feed_beat;

  // ---------------------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    beat_d    = beat_q;
    drain_d   = drain_q;
    row_d     = row_q;
    prior_d   = prior_q;
    done_d    = 1'b0;
    arr_en    = 1'b0;
    arr_clr   = 1'b0;
    feed_beat = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          k_d     = cfg_k;
          beat_d  = '0;
          drain_d = '0;
          row_d   = '0;
          // Skipping the clear is only safe when the array holds a finished C.
          if (cfg_acc && prior_q) begin
            state_d = (cfg_k == '0) ? StRead : StFeed;
          end else begin
            state_d = StClear;
          end
        end
      end
      StClear: begin
        arr_clr = 1'b1;
        state_d = (k_q == '0) ? StRead : StFeed;
      end
      StFeed: begin
        in_ready = 1'b1;
        if (in_valid) begin
          arr_en    = 1'b1;
          feed_beat = 1'b1;
          beat_d    = beat_q + KW'(1);
          if (beat_q == k_q - KW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Zero beats push the last real operands through the skew and the PE chain.
        arr_en  = 1'b1;
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(DrainLast)) begin
          state_d = StRead;
        end
      end
      StRead: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (row_q == IW'(N - 1)) begin
            state_d = StIdle;
            row_d   = '0;
            done_d  = 1'b1;
            prior_d = 1'b1;
          end else begin
            row_d = row_q + IW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      row_d   = '0;
      done_d  = 1'b0;
      prior_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      row_q   <= '0;
      prior_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      row_q   <= row_d;
      prior_q <= prior_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign out_idx  = (state_q == StRead) ? row_q : '0;
  assign out_last = (state_q == StRead) && (row_q == IW'(N - 1));

  // ---------------------------------------------------------------------------------------
  // Systolic array: operand skew, PE pass-through registers, accumulators
  // ---------------------------------------------------------------------------------------
  logic signed [W-1:0]     op_a     [N];
  logic signed [W-1:0]     op_b     [N];
  logic signed [W-1:0]     a_row_in [N];
  logic signed [W-1:0]     b_col_in [N];
  logic signed [W-1:0]     a_in     [N][N];
  logic signed [W-1:0]     b_in     [N][N];
  logic signed [W-1:0]     a_h_q    [N][N-1];
  logic signed [W-1:0]     a_h_d    [N][N-1];
  logic signed [W-1:0]     b_v_q    [N-1][N];
  logic signed [W-1:0]     b_v_d    [N-1][N];
  logic signed [ACC_W-1:0] acc_q    [N][N];
  logic signed [ACC_W-1:0] acc_d    [N][N];

  // Stalled cycles and drain cycles present zero operands.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      op_a[i] = feed_beat ? $signed(a_vec_flat[i*W +: W]) : '0;
      op_b[i] = feed_beat ? $signed(b_vec_flat[i*W +: W]) : '0;
    end
  end

  // Row i of A and column i of B are delayed by i enabled steps so that A[r][k] and
  // B[k][c] meet in PE(r,c) on the same step.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_row_in[gi] = op_a[gi];
      assign b_col_in[gi] = op_b[gi];
    end else begin : g_delay
      logic signed [W-1:0] sa_q [gi];
      logic signed [W-1:0] sa_d [gi];
      logic signed [W-1:0] sb_q [gi];
      logic signed [W-1:0] sb_d [gi];

      always_comb begin
        sa_d = sa_q;
        sb_d = sb_q;
        if (arr_clr) begin
          for (int d = 0; d < gi; d++) begin
            sa_d[d] = '0;
            sb_d[d] = '0;
          end
        end else if (arr_en) begin
          sa_d[0] = op_a[gi];
          sb_d[0] = op_b[gi];
          for (int d = 1; d < gi; d++) begin
            sa_d[d] = sa_q[d-1];
            sb_d[d] = sb_q[d-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < gi; d++) begin
            sa_q[d] <= '0;
            sb_q[d] <= '0;
          end
        end else begin
          sa_q <= sa_d;
          sb_q <= sb_d;
        end
      end

      assign a_row_in[gi] = sa_q[gi-1];
      assign b_col_in[gi] = sb_q[gi-1];
    end
  end

  // A flows left to right, B flows top to bottom.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (gj == 0) begin : g_a_edge
        assign a_in[gi][gj] = a_row_in[gi];
      end else begin : g_a_inner
        assign a_in[gi][gj] = a_h_q[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in[gi][gj] = b_col_in[gj];
      end else begin : g_b_inner
        assign b_in[gi][gj] = b_v_q[gi-1][gj];
      end
    end
  end

  always_comb begin
    a_h_d = a_h_q;
    b_v_d = b_v_q;
    acc_d = acc_q;
    if (arr_clr) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) acc_d[i][j] = '0;
        for (int j = 0; j < N - 1; j++) a_h_d[i][j] = '0;
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) b_v_d[i][j] = '0;
      end
    end else if (arr_en) begin
      // Products are formed at accumulator width; sums wrap at ACC_W bits.
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_d[i][j] = acc_q[i][j] + ACC_W'(a_in[i][j]) * ACC_W'(b_in[i][j]);
        end
        for (int j = 0; j < N - 1; j++) a_h_d[i][j] = a_in[i][j];
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) b_v_d[i][j] = b_in[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) acc_q[i][j] <= '0;
        for (int j = 0; j < N - 1; j++) a_h_q[i][j] <= '0;
      end
      for (int i = 0; i < N - 1; i++) begin
        for (int j = 0; j < N; j++) b_v_q[i][j] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      a_h_q <= a_h_d;
      b_v_q <= b_v_d;
    end
  end

  always_comb begin
    out_row = '0;
    if (state_q == StRead) begin
      for (int j = 0; j < N; j++) out_row[j*ACC_W +: ACC_W] = acc_q[row_q][j];
    end
  end

  // ---------------------------------------------------------------------------------------
  // Busy-cycle counter
  // ---------------------------------------------------------------------------------------
`ifdef TPU_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] perf_q, perf_d;

  always_comb begin
    cyc_d  = (state_q == StIdle) ? '0 : cyc_q + 32'd1;
    perf_d = perf_q;
    // Latched on the same edge that raises done, so both become visible together.
    if (done_d) begin
      perf_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      perf_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_tpu_stream_core.sv
// Testbench for tpu_stream_core (N=2, W=8, ACC_W=20, KW=16).
// A table of complete jobs is run back to back, followed by hand-written sequences for
// stalled handshakes, K=0, abort during drain, reset mid-job and the wide-operand job.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_tpu_stream_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_k;
  logic        cfg_acc;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_vec_flat;
  logic [15:0] b_vec_flat;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_row;
  logic [0:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [31:0] perf_cycles;

  int checks = 0;
  int errors = 0;

  logic [15:0] a_beats [16];
  logic [15:0] b_beats [16];

  typedef struct {
    int          k;
    bit          acc;
    logic [15:0] a0, a1, b0, b1;
    logic        exp_ready0;  // in_ready one cycle after start: 0 = clear taken
    logic [39:0] r0, r1;
  } vec_t;

  vec_t tbl [5];

  tpu_stream_core #(
    .N    (2),
    .W    (8),
    .ACC_W(20),
    .KW   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cfg_k      (cfg_k),
    .cfg_acc    (cfg_acc),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_vec_flat (a_vec_flat),
    .b_vec_flat (b_vec_flat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pk2(input int hi, input int lo);
    logic [31:0] h, l;
    h = hi;
    l = lo;
    return {h[7:0], l[7:0]};
  endfunction

  function automatic logic [39:0] row2(input int c1, input int c0);
    logic [31:0] h, l;
    h = c1;
    l = c0;
    return {h[19:0], l[19:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Feeds k beats from a_beats/b_beats; with stall set, in_valid is low every other cycle.
  task automatic feed(input int k, input int stall);
    int   beat;
    int   t;
    logic fire;
    beat = 0;
    t    = 0;
    while (beat < k && t < 500) begin
      in_valid   = (stall != 0) ? (t % 2 == 1) : 1'b1;
      a_vec_flat = a_beats[beat];
      b_vec_flat = b_beats[beat];
      fire       = in_valid && in_ready;
      @(negedge clk);
      t++;
      if (fire) beat++;
    end
    in_valid   = 1'b0;
    a_vec_flat = '0;
    b_vec_flat = '0;
    if (beat < k) timeout("feed");
  endtask

  task automatic run_job(input int k, input bit acc, input int stall_in, input int stall_out,
                         output logic [39:0] r0, output logic [39:0] r1,
                         output logic first_ready);
    int t;
    r0 = '0;
    r1 = '0;
    @(negedge clk);
    start   = 1'b1;
    cfg_k   = 16'(k);
    cfg_acc = acc;
    @(negedge clk);
    start       = 1'b0;
    cfg_acc     = 1'b0;
    first_ready = in_ready;
    feed(k, stall_in);
    for (int r = 0; r < 2; r++) begin
      t = 0;
      while (!out_valid && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!out_valid) timeout("out_valid");
      if (r == 0) begin
        for (int s = 0; s < stall_out; s++) begin
          @(negedge clk);
          chk("row_hold_valid", 64'(out_valid), 64'd1);
          chk("row_hold_idx", 64'(out_idx), 64'd0);
        end
      end
      chk("out_idx", 64'(out_idx), 64'(r));
      chk("out_last", 64'(out_last), 64'(r == 1));
      if (r == 0) r0 = out_row;
      else        r1 = out_row;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("done_pulse", 64'(done), 64'd1);
    chk("idle_after_job", 64'({busy, out_valid, in_ready}), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic set_base_beats();
    // A = [[1,2],[3,4]], B = [[5,6],[7,8]]
    a_beats[0] = pk2(3, 1);
    a_beats[1] = pk2(4, 2);
    b_beats[0] = pk2(6, 5);
    b_beats[1] = pk2(8, 7);
  endtask

  initial begin
    logic [39:0] r0, r1;
    logic        fr;
    logic [39:0] base0, base1;
    logic [31:0] exp_perf;

    base0 = row2(22, 19);
    base1 = row2(50, 43);

    tbl[0] = '{k: 2, acc: 1'b0, a0: pk2(3, 1), a1: pk2(4, 2), b0: pk2(6, 5), b1: pk2(8, 7),
               exp_ready0: 1'b0, r0: base0, r1: base1};
    tbl[1] = '{k: 2, acc: 1'b1, a0: pk2(3, 1), a1: pk2(4, 2), b0: pk2(6, 5), b1: pk2(8, 7),
               exp_ready0: 1'b1, r0: row2(44, 38), r1: row2(100, 86)};
    tbl[2] = '{k: 2, acc: 1'b0, a0: pk2(3, 1), a1: pk2(4, 2), b0: pk2(6, 5), b1: pk2(8, 7),
               exp_ready0: 1'b0, r0: base0, r1: base1};
    // A = [[2],[-3]], B = [[-5,4]]
    tbl[3] = '{k: 1, acc: 1'b0, a0: pk2(-3, 2), a1: '0, b0: pk2(4, -5), b1: '0,
               exp_ready0: 1'b0, r0: row2(8, -10), r1: row2(-12, 15)};
    tbl[4] = '{k: 2, acc: 1'b1, a0: pk2(3, 1), a1: pk2(4, 2), b0: pk2(6, 5), b1: pk2(8, 7),
               exp_ready0: 1'b1, r0: row2(30, 9), r1: row2(38, 58)};

    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_k      = '0;
    cfg_acc    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a_vec_flat = '0;
    b_vec_flat = '0;

    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({busy, done, in_ready, out_valid, out_last, out_idx}), 64'd0);
    chk("reset_row", 64'(out_row), 64'd0);
    chk("reset_perf", 64'(perf_cycles), 64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      a_beats[0] = tbl[v].a0;
      a_beats[1] = tbl[v].a1;
      b_beats[0] = tbl[v].b0;
      b_beats[1] = tbl[v].b1;
      run_job(tbl[v].k, tbl[v].acc, 0, 0, r0, r1, fr);
      chk($sformatf("tbl%0d_clear_path", v), 64'(fr), 64'(tbl[v].exp_ready0));
      chk($sformatf("tbl%0d_row0", v), 64'(r0), 64'(tbl[v].r0));
      chk($sformatf("tbl%0d_row1", v), 64'(r1), 64'(tbl[v].r1));
    end

    // Stalled input and output handshakes.
    set_base_beats();
    run_job(2, 1'b0, 1, 3, r0, r1, fr);
    chk("stall_row0", 64'(r0), 64'(base0));
    chk("stall_row1", 64'(r1), 64'(base1));

    // K = 0: straight from CLEAR to READ with zero rows.
    run_job(0, 1'b0, 0, 0, r0, r1, fr);
    chk("k0_clear_path", 64'(fr), 64'd0);
    chk("k0_row0", 64'(r0), 64'd0);
    chk("k0_row1", 64'(r1), 64'd0);

    // Abort during DRAIN, then an accumulate job must still clear.
    @(negedge clk);
    start   = 1'b1;
    cfg_k   = 16'd2;
    cfg_acc = 1'b0;
    @(negedge clk);
    start = 1'b0;
    feed(2, 0);
    chk("drain_busy", 64'({busy, in_ready, out_valid}), 64'b100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 64'({busy, done}), 64'd0);
    @(negedge clk);
    chk("abort_no_done", 64'(done), 64'd0);
    run_job(2, 1'b1, 0, 0, r0, r1, fr);
    chk("post_abort_clear_path", 64'(fr), 64'd0);
    chk("post_abort_row0", 64'(r0), 64'(base0));
    chk("post_abort_row1", 64'(r1), 64'(base1));

    // Reset in the middle of an accumulate job.
    @(negedge clk);
    start   = 1'b1;
    cfg_k   = 16'd2;
    cfg_acc = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cfg_acc = 1'b0;
    chk("acc_skip_clear", 64'(in_ready), 64'd1);
    feed(1, 0);
    rst_n = 1'b0;
    #2;
    chk("midjob_reset", 64'({busy, done, in_ready, out_valid, out_row}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(2, 1'b1, 0, 0, r0, r1, fr);
    chk("post_reset_clear_path", 64'(fr), 64'd0);
    chk("post_reset_row0", 64'(r0), 64'(base0));
    chk("post_reset_row1", 64'(r1), 64'(base1));

    // Most negative operands, K = 16: 16 * 16384 = 262144 per element.
    for (int i = 0; i < 16; i++) begin
      a_beats[i] = 16'h8080;
      b_beats[i] = 16'h8080;
    end
    run_job(16, 1'b0, 0, 0, r0, r1, fr);
    chk("neg_row0", 64'(r0), 64'({20'h40000, 20'h40000}));
    chk("neg_row1", 64'(r1), 64'({20'h40000, 20'h40000}));
`ifdef TPU_PERF_CNT_EN
    exp_perf = 32'd22;
`else
    exp_perf = 32'd0;
`endif
    chk("perf_cycles", 64'(perf_cycles), 64'(exp_perf));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_stream_core.md
TPU_STREAM_CORE -- requirements
Module: tpu_stream_core

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning array dimension (N x N PEs), legal N>=2.
REQ-002 The block SHALL have parameter W, default 8, meaning signed operand width.
REQ-003 The block SHALL have parameter ACC_W, default 2*W+4, meaning signed accumulator width.
REQ-004 The block SHALL have parameter KW, default 16, meaning width of cfg_k.
REQ-005 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port start  input  1  job request, accepted only in IDLE.
REQ-008 The block SHALL have port abort  input  1  cancel current job.
REQ-009 The block SHALL have port cfg_k  input  KW  inner dimension K, sampled on accepted start.
REQ-010 The block SHALL have port cfg_acc  input  1  1 = accumulate onto previous C (skip clear), sampled on accepted start.
REQ-011 The block SHALL have ports in_valid/in_ready  input/output  1/1  operand beat handshake.
REQ-012 The block SHALL have ports a_vec_flat, b_vec_flat  input  N*W each  {x[N-1],...,x[0]} per beat.
REQ-013 The block SHALL have ports out_valid/out_ready  output/input  1/1  result row handshake.
REQ-014 The block SHALL have port out_row  output  N*ACC_W  row r of C, {C[r][N-1],...,C[r][0]}.
REQ-015 The block SHALL have ports out_idx/out_last  output  $clog2(N)/1  current row index; high on row N-1.
REQ-016 The block SHALL have ports busy/done  output  1/1  job active; 1-cycle completion pulse.
REQ-017 The block SHALL have port perf_cycles  output  32  busy-cycle count of last job.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN, READ; busy = state != IDLE.
REQ-019 IDLE -> CLEAR on start, or IDLE -> FEED on start with cfg_acc=1 and a prior completed job since reset.
REQ-020 CLEAR SHALL last one cycle, hold the existing systolic_array in clear, then go to FEED, or to READ if K=0.
REQ-021 FEED: in_ready=1; each cycle with in_valid=1 SHALL enable the array with the beat and count it; in_valid=0 SHALL stall the array (en=0, operands zero).
REQ-022 FEED -> DRAIN on the K-th accepted beat; DRAIN SHALL enable the array with zero operands for exactly 2*(N-1)+1 cycles, then go to READ.
REQ-023 READ: out_valid=1, rows 0..N-1 in order, row advances only on out_valid&&out_ready, array enable low so C is stable.
REQ-024 The final row handshake SHALL return the FSM to IDLE and assert done for exactly one cycle in the following cycle.
REQ-025 abort in any non-IDLE state SHALL return to IDLE next cycle, with no done and the prior-job flag cleared (next cfg_acc forced to clear).
REQ-026 start while busy SHALL be ignored; abort and start together in IDLE: start wins.
REQ-027 Arithmetic SHALL be signed two's complement with ACC_W wrap-around and no saturation.
REQ-028 in_ready, out_valid SHALL be 0 outside FEED and READ respectively; out_row SHALL be 0 outside READ.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, all counters 0, prior-job flag 0, done 0, perf_cycles 0, and every output low/zero.
REQ-030 Reset mid-job SHALL discard the job; the array SHALL be cleared before its next use.

Configuration
REQ-031 With macro TPU_PERF_CNT_EN defined, perf_cycles SHALL count busy cycles per job and latch the count with done.
REQ-032 Without TPU_PERF_CNT_EN, perf_cycles SHALL be tied to 0 and no counter logic generated.

Verification
REQ-033 N=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]], K=2, continuous valid/ready -> rows [19,22],[43,50], done once.
REQ-034 Same job with in_valid low every other cycle and out_ready low 3 cycles -> identical rows, no lost/duplicated beats.
REQ-035 Repeat REQ-033 job with cfg_acc=1 -> rows [38,44],[86,100]; then cfg_acc=0 -> [19,22],[43,50].
REQ-036 K=0 -> READ entered after CLEAR, two zero rows, done pulse.
REQ-037 abort during DRAIN, then cfg_acc=1 job of REQ-033 -> CLEAR taken, rows [19,22],[43,50].
REQ-038 Operands -128 x -128, K=16, with TPU_PERF_CNT_EN -> C=262144 per element, perf_cycles=1+16+3+2=22.
